// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage for an 8-entry x 4-bit FIFO.
// It arbitrates write and read requests and keeps the write pointer, read
// pointer and occupancy count. It drives the storage bank strobes and
// addresses, and it produces the registered ack/error handshake status.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds the almost_full and
// almost_empty outputs.
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       we,
  output logic       re,
  output logic [2:0] wr_addr,
  output logic [2:0] rd_addr,
  output logic       full,
  output logic       empty,
  output logic [3:0] data_count,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic       almost_full,
  output logic       almost_empty
`endif
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_t;

  state_t     state_reg;
  logic [2:0] wr_ptr_reg;
  logic [2:0] rd_ptr_reg;
  logic [3:0] count_reg;
  logic       wr_only;
  logic       rd_only;

  // A simultaneous write and read request is a defined no-op.
  // Only a request from exactly one side is acted on.
  assign wr_only = wr_en & ~rd_en;
  assign rd_only = rd_en & ~wr_en;

  assign full  = (count_reg == 4'd8);
  assign empty = (count_reg == 4'd0);

  // The strobes are also gated by reset_n.
  // This keeps the storage bank quiet while reset is held, even if a
  // request is already present.
  assign we = reset_n & wr_only & ~full;
  assign re = reset_n & rd_only & ~empty;

  assign wr_addr    = wr_ptr_reg;
  assign rd_addr    = rd_ptr_reg;
  assign data_count = count_reg;

  // Handshake status is decoded from the state register alone.
  // Each pulse therefore lasts exactly one cycle per request.
  assign wr_ack = (state_reg == WRITE);
  assign wr_err = (state_reg == WR_ERROR);
  assign rd_ack = (state_reg == READ);
  assign rd_err = (state_reg == RD_ERROR);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count_reg >= 4'd7);
  assign almost_empty = (count_reg <= 4'd1);
`endif

  // Request FSM: the same next-state decode applies from every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= INIT;
    end else if (wr_only) begin
      state_reg <= full ? WR_ERROR : WRITE;
    end else if (rd_only) begin
      state_reg <= empty ? RD_ERROR : READ;
    end else begin
      state_reg <= NO_OP;
    end
  end

  // Pointers and occupancy advance only on accepted strobes.
  // The 3-bit pointers wrap from 7 to 0 naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= 3'd0;
      rd_ptr_reg <= 3'd0;
      count_reg  <= 4'd0;
    end else begin
      if (we) begin
        wr_ptr_reg <= wr_ptr_reg + 3'd1;
      end
      if (re) begin
        rd_ptr_reg <= rd_ptr_reg + 3'd1;
      end
      if (we) begin
        count_reg <= count_reg + 4'd1;
      end else if (re) begin
        count_reg <= count_reg - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl.
// It contains a transaction-level model that counts accepted writes and
// reads. Every negative clock edge it compares all DUT outputs against that
// model. Literal expectations at the test-plan points pin the model itself.
module tb_fifo_ctrl;
  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic       we;
  logic       re;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic       full;
  logic       empty;
  logic [3:0] data_count;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int errors = 0;
  int checks = 0;

  fifo_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .re         (re),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: total accepted writes and reads since reset, plus the outcome
  // of the previous request.
  int mw = 0;
  int mr = 0;
  bit m_wa = 0, m_we = 0, m_ra = 0, m_re = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mw <= 0; mr <= 0;
      m_wa <= 0; m_we <= 0; m_ra <= 0; m_re <= 0;
    end else begin
      m_wa <= wr_en && !rd_en && (mw - mr) < 8;
      m_we <= wr_en && !rd_en && (mw - mr) == 8;
      m_ra <= rd_en && !wr_en && (mw - mr) > 0;
      m_re <= rd_en && !wr_en && (mw - mr) == 0;
      if (wr_en && !rd_en && (mw - mr) < 8) mw <= mw + 1;
      if (rd_en && !wr_en && (mw - mr) > 0) mr <= mr + 1;
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    int cnt;
    cnt = mw - mr;
    check("we", we, int'(reset_n && wr_en && !rd_en && cnt < 8));
    check("re", re, int'(reset_n && rd_en && !wr_en && cnt > 0));
    check("data_count", data_count, cnt);
    check("full", full, int'(cnt == 8));
    check("empty", empty, int'(cnt == 0));
    check("wr_addr", wr_addr, mw % 8);
    check("rd_addr", rd_addr, mr % 8);
    check("wr_ack", wr_ack, int'(m_wa));
    check("wr_err", wr_err, int'(m_we));
    check("rd_ack", rd_ack, int'(m_ra));
    check("rd_err", rd_err, int'(m_re));
`ifdef FIFO_ALMOST_FLAGS_EN
    check("almost_full", almost_full, int'(cnt >= 7));
    check("almost_empty", almost_empty, int'(cnt <= 1));
`endif
  end

  // Present one request for one sampling edge.
  // Return 1 time unit after that edge.
  task automatic cyc(input bit w, input bit r);
    wr_en = w;
    rd_en = r;
    @(posedge clk);
    #1;
    $display("txn wr_en=%0b rd_en=%0b -> count=%0d wr_addr=%0d rd_addr=%0d ack/err w=%0b/%0b r=%0b/%0b",
             w, r, data_count, wr_addr, rd_addr, wr_ack, wr_err, rd_ack, rd_err);
  endtask

  // Pulse the asynchronous reset between clock edges.
  task automatic async_reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    check("rst_count", data_count, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_ack", wr_ack, 0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset_n = 1'b0;
    #2;
    check("init_empty", empty, 1);
    check("init_full", full, 0);
    check("init_count", data_count, 0);
    check("init_wr_addr", wr_addr, 0);
    check("init_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    #10 reset_n = 1'b1;

    // Idle after reset.
    cyc(0, 0);
    cyc(0, 0);
    check("idle_empty", empty, 1);
    check("idle_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);

    // Three writes, then an asynchronous reset in mid-cycle.
    for (int i = 0; i < 3; i++) cyc(1, 0);
    check("w3_count", data_count, 3);
    check("w3_wr_addr", wr_addr, 3);
    async_reset_pulse();

    // Eight writes fill the FIFO and wrap the write pointer.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      check("fill_count", data_count, i + 1);
      check("fill_wr_ack", wr_ack, 1);
    end
    check("fill_full", full, 1);
    check("fill_wr_addr", wr_addr, 0);
    wr_en = 1'b1;
    rd_en = 1'b0;
    #1 check("w9_we", we, 0);
    cyc(1, 0);
    check("w9_wr_err", wr_err, 1);
    check("w9_count", data_count, 8);
    cyc(1, 0);
    check("w10_wr_err", wr_err, 1);

    // Eight reads drain the FIFO.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1);
      check("drain_count", data_count, 7 - i);
      check("drain_rd_ack", rd_ack, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_rd_addr", rd_addr, 0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #1 check("r9_re", re, 0);
    cyc(0, 1);
    check("r9_rd_err", rd_err, 1);

    // Simultaneous requests at count 4 do nothing.
    for (int i = 0; i < 4; i++) cyc(1, 0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1 check("both_strobes", {we, re}, 0);
    cyc(1, 1);
    check("both_count", data_count, 4);
    check("both_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);

    // Wrap-around from a clean reset: write 6, read 6, write 5.
    async_reset_pulse();
    for (int i = 0; i < 6; i++) cyc(1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    check("wrap_wr_addr", wr_addr, 3);
    check("wrap_rd_addr", rd_addr, 6);
    check("wrap_count", data_count, 5);
    check("wrap_flags", {full, empty}, 0);

    // Almost flags at count 7 and at count 1.
    cyc(1, 0);
    cyc(1, 0);
    check("c7_full", full, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
    check("c7_almost_full", almost_full, 1);
`endif
    for (int i = 0; i < 6; i++) cyc(0, 1);
    check("c1_empty", empty, 0);
    check("c1_count", data_count, 1);
`ifdef FIFO_ALMOST_FLAGS_EN
    check("c1_almost_empty", almost_empty, 1);
`endif

    cyc(0, 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control stage for the 8-entry, 4-bit-wide FIFO. It arbitrates write/read requests, keeps the write pointer, read pointer and occupancy count, and drives the storage bank of resettable 4-bit registers directly downstream (write strobe plus write/read addresses). It also produces registered handshake status (ack/error) and full/empty flags for the producer and consumer.

## Interface

Parameters: none. Depth is fixed at 8, pointers 3 bits, count 4 bits.

Ports:
- clk  in  1  single rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request, sampled each rising edge
- rd_en  in  1  read request, sampled each rising edge
- we  out  1  storage write strobe (combinational); storage captures d_in at `mem[wr_addr]` on the same edge
- re  out  1  read strobe (combinational); downstream output register captures `mem[rd_addr]` on the same edge
- wr_addr  out  3  current write pointer
- rd_addr  out  3  current read pointer
- full  out  1  data_count == 8
- empty  out  1  data_count == 0
- data_count  out  4  occupancy, 0..8
- wr_ack  out  1  previous request was an accepted write
- wr_err  out  1  previous request was a write while full
- rd_ack  out  1  previous request was an accepted read
- rd_err  out  1  previous request was a read while empty

## Operation

- State register, 6 states: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. All transitions are taken at the rising edge from the sampled wr_en/rd_en and the current full/empty.
- Next-state decode, the same from every state:
  - wr_en=1, rd_en=0, !full -> WRITE
  - wr_en=1, rd_en=0, full -> WR_ERROR
  - rd_en=1, wr_en=0, !empty -> READ
  - rd_en=1, wr_en=0, empty -> RD_ERROR
  - both 0, or both 1 -> NO_OP
- Simultaneous wr_en and rd_en is a defined no-op: no strobe, no pointer change, no ack, no error.
- Strobes: `we = wr_en & ~rd_en & ~full`; `re = rd_en & ~wr_en & ~empty`.
- Edge with we=1: wr_ptr <= wr_ptr+1 (mod 8, 7 wraps to 0); data_count <= data_count+1.
- Edge with re=1: rd_ptr <= rd_ptr+1 (mod 8); data_count <= data_count-1.
- Error requests change no pointer and no count. data_count never leaves 0..8.
- Status outputs decode from state only: wr_ack=WRITE, wr_err=WR_ERROR, rd_ack=READ, rd_err=RD_ERROR. INIT and NO_OP drive all four low.
- full and empty decode from the registered data_count. They are never both 1.
- Reset (asynchronous assert, at any time including mid-operation): state=INIT, wr_ptr=0, rd_ptr=0, data_count=0, so empty=1, full=0, all acks/errors 0, we=re=0 while reset_n=0. Storage contents are not cleared by this block.

## Timing

- Request latency: the strobe is in the same cycle as the request; pointer/count update at the sampling edge; ack/error is valid for exactly the one cycle after that edge.
- full/empty/data_count reflect an accepted op in the cycle after its edge.
- Back-to-back requests sustain one op per cycle.
- Write into a full FIFO, or read from an empty one, while the other side is idle: the error pulse repeats each cycle the request is held.
- Reset release: the first edge with reset_n=1 performs normal decode from INIT.

## Configuration

- FIFO_ALMOST_FLAGS_EN defined: adds outputs almost_full (data_count >= 7) and almost_empty (data_count <= 1), both combinational from data_count. Reset values: almost_full=0, almost_empty=1.
- Not defined: these ports do not exist, and the rest of the behaviour is unchanged.

## Test plan

- Reset then idle: empty=1, full=0, data_count=0, wr_addr=rd_addr=0, all acks 0. An async reset_n pulse mid-cycle after 3 writes immediately restores these values.
- 8 consecutive writes: we=1 each cycle, wr_ack=1 for 8 cycles, data_count 1..8, full=1, wr_addr wraps to 0. A 9th write gives wr_err=1, we=0, count stays 8.
- From full, 8 reads: rd_ack pulses and data_count 7..0. The 8th read leaves empty=1 and rd_addr=0. A 9th read gives rd_err=1 and re=0.
- wr_en=rd_en=1 with count=4: no strobes, count stays 4, all acks/errors 0 (state NO_OP).
- Wrap-around: write 6, read 6, write 5, giving wr_addr=3, rd_addr=6, data_count=5, with no false full/empty.
- With FIFO_ALMOST_FLAGS_EN: count 7 gives almost_full=1, full=0. Count 1 gives almost_empty=1, empty=0.
